stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_stage_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer: walks IF/ID/EX/MEM/WB per opcode class,
// supports stall, optional memory handshake, sticky halt and retire/cycle counters.
module stage_sequencer #(
   parameter int EX_CYCLES     = 1,
   parameter bit MEM_HANDSHAKE = 1'b0,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       opcode,
   input  logic             stall,
   input  logic             mem_ready,
   input  logic             halt_req,
   output logic             enable_IF,
   output logic             enable_ID,
   output logic             enable_EX,
   output logic             enable_MEM,
   output logic             enable_WB,
   output logic [2:0]       stage_num,
   output logic             instr_done,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count,
   output logic [CNT_W-1:0] cycle_count
);

   typedef enum logic [2:0] {
      ST_IF   = 3'd0,
      ST_ID   = 3'd1,
      ST_EX   = 3'd2,
      ST_MEM  = 3'd3,
      ST_WB   = 3'd4,
      ST_HALT = 3'd5
   } state_t;

   localparam logic [3:0] EX_LAST = 4'(EX_CYCLES - 32'sd1);

   state_t             state_r;
   state_t             next_state_s;
   logic               retire_s;
   logic               ex_last_s;
   logic               mem_exit_s;
   logic [3:0]         ex_cnt_r;
   logic [3:0]         op_q_r;
   logic [2:0]         stage_num_r;
   logic [4:0]         enables_r;
   logic               instr_done_r;
   logic               halted_r;
   logic [CNT_W-1:0]   instr_count_r;
   logic [CNT_W-1:0]   cycle_count_r;

   function automatic logic is_jump(input logic [3:0] op);
      return (op[3:2] == 2'b11) && (op[1:0] != 2'b11);
   endfunction

   function automatic logic is_branch(input logic [3:0] op);
      return op[3:2] == 2'b10;
   endfunction

   function automatic logic is_alu(input logic [3:0] op);
      return op <= 4'b0100;
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return op[2:0] == 3'b111;
   endfunction

   // Bit order is {WB, MEM, EX, ID, IF}; HALT drives no stage.
   function automatic logic [4:0] stage_enables(input state_t st);
      logic [4:0] en;
      case (st)
         ST_IF:   en = 5'b00001;
         ST_ID:   en = 5'b00010;
         ST_EX:   en = 5'b00100;
         ST_MEM:  en = 5'b01000;
         ST_WB:   en = 5'b10000;
         default: en = 5'b00000;
      endcase
      return en;
   endfunction

   assign ex_last_s  = (ex_cnt_r == EX_LAST);
   assign mem_exit_s = MEM_HANDSHAKE ? mem_ready : 1'b1;

   // Next-stage routing; ID decides on the live opcode, later stages on op_q.
   always_comb begin
      next_state_s = state_r;
      retire_s     = 1'b0;
      case (state_r)
         ST_IF: begin
            next_state_s = ST_ID;
         end
         ST_ID: begin
            if (is_jump(opcode)) begin
               retire_s = 1'b1;
            end else begin
               next_state_s = ST_EX;
            end
         end
         ST_EX: begin
            if (!ex_last_s) begin
               next_state_s = ST_EX;
            end else if (is_branch(op_q_r)) begin
               retire_s = 1'b1;
            end else if (is_alu(op_q_r)) begin
               next_state_s = ST_WB;
            end else begin
               next_state_s = ST_MEM;
            end
         end
         ST_MEM: begin
            if (!mem_exit_s) begin
               next_state_s = ST_MEM;
            end else if (is_store(op_q_r)) begin
               retire_s = 1'b1;
            end else begin
               next_state_s = ST_WB;
            end
         end
         ST_WB: begin
            retire_s = 1'b1;
         end
         ST_HALT: begin
            next_state_s = ST_HALT;
         end
         default: begin
            next_state_s = ST_IF;
         end
      endcase
      if (retire_s) begin
         next_state_s = halt_req ? ST_HALT : ST_IF;
      end else begin
         next_state_s = next_state_s;
      end
   end

   // Sequencer state, registered outputs and counters; stall freezes everything but cycle_count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r       <= ST_IF;
         stage_num_r   <= 3'd0;
         enables_r     <= 5'b00001;
         instr_done_r  <= 1'b0;
         halted_r      <= 1'b0;
         instr_count_r <= '0;
         cycle_count_r <= '0;
         ex_cnt_r      <= 4'd0;
         op_q_r        <= 4'd0;
      end else begin
         if (state_r != ST_HALT) begin
            cycle_count_r <= cycle_count_r + CNT_W'(1'b1);
         end
         if (stall || (state_r == ST_HALT)) begin
            instr_done_r <= 1'b0;
         end else begin
            state_r      <= next_state_s;
            stage_num_r  <= next_state_s;
            enables_r    <= stage_enables(next_state_s);
            halted_r     <= (next_state_s == ST_HALT);
            instr_done_r <= retire_s;
            if (retire_s) begin
               instr_count_r <= instr_count_r + CNT_W'(1'b1);
            end
            if (state_r == ST_ID) begin
               op_q_r <= opcode;
            end
            // ex_cnt rests at zero outside EX, so every EX entry starts fresh.
            if ((state_r == ST_EX) && !ex_last_s) begin
               ex_cnt_r <= ex_cnt_r + 4'd1;
            end else begin
               ex_cnt_r <= 4'd0;
            end
         end
      end
   end

   assign enable_IF   = enables_r[0];
   assign enable_ID   = enables_r[1];
   assign enable_EX   = enables_r[2];
   assign enable_MEM  = enables_r[3];
   assign enable_WB   = enables_r[4];
   assign stage_num   = stage_num_r;
   assign instr_done  = instr_done_r;
   assign halted      = halted_r;
   assign instr_count = instr_count_r;
   assign cycle_count = cycle_count_r;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: two instances (default parameters and EX_CYCLES=3/handshake/4-bit
// counters) checked cycle by cycle against a per-instruction stage schedule model.
module tb_stage_sequencer;

   logic clk;
   logic [1:0] rst_n_v, stall_v, hreq_v, mr_v;
   logic [3:0] op_v [2];
   logic [2:0] sn0, sn1;
   logic [4:0] en0, en1;
   logic dn0, dn1, h0, h1;
   logic [15:0] ic0, cc0;
   logic [3:0] ic1, cc1;

   int total = 0;
   int bad = 0;
   int exp_ic [2];
   int exp_cc [2];
   bit exp_done [2];

   stage_sequencer u_dut0 (
      .clk(clk), .rst_n(rst_n_v[0]), .opcode(op_v[0]), .stall(stall_v[0]),
      .mem_ready(mr_v[0]), .halt_req(hreq_v[0]),
      .enable_IF(en0[0]), .enable_ID(en0[1]), .enable_EX(en0[2]), .enable_MEM(en0[3]),
      .enable_WB(en0[4]), .stage_num(sn0), .instr_done(dn0), .halted(h0),
      .instr_count(ic0), .cycle_count(cc0));

   stage_sequencer #(.EX_CYCLES(3), .MEM_HANDSHAKE(1'b1), .CNT_W(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n_v[1]), .opcode(op_v[1]), .stall(stall_v[1]),
      .mem_ready(mr_v[1]), .halt_req(hreq_v[1]),
      .enable_IF(en1[0]), .enable_ID(en1[1]), .enable_EX(en1[2]), .enable_MEM(en1[3]),
      .enable_WB(en1[4]), .stage_num(sn1), .instr_done(dn1), .halted(h1),
      .instr_count(ic1), .cycle_count(cc1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int exc(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic bit hs(input int d);
      return d == 1;
   endfunction

   function automatic int cmask(input int d);
      return (d == 0) ? 32'h0000_FFFF : 32'h0000_000F;
   endfunction

   function automatic logic [4:0] en_of(input int s);
      if (s < 5) return 5'(1 << s);
      else return 5'd0;
   endfunction

   function automatic logic [9:0] status(input int d);
      return (d == 0) ? {sn0, en0, dn0, h0} : {sn1, en1, dn1, h1};
   endfunction

   function automatic logic [31:0] counts(input int d);
      return (d == 0) ? {ic0, cc0} : {12'd0, ic1, 12'd0, cc1};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset(input int d);
      rst_n_v[d] = 1'b0;
      stall_v[d] = 1'($urandom);
      hreq_v[d]  = 1'($urandom);
      op_v[d]    = 4'($urandom);
      mr_v[d]    = 1'($urandom);
      step();
      step();
      total++;
      if (status(d) !== {3'd0, 5'b00001, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL reset_status dut%0d: got %b want %b", d, status(d), {3'd0, 5'b00001, 2'b00});
      end
      total++;
      if (counts(d) !== 32'd0) begin
         bad++;
         $display("FAIL reset_counts dut%0d: got %h want 0", d, counts(d));
      end
      rst_n_v[d] = 1'b1;
      stall_v[d] = 1'b0;
      hreq_v[d]  = 1'b0;
      exp_ic[d] = 0;
      exp_cc[d] = 0;
      exp_done[d] = 1'b0;
   endtask

   // Drives one instruction and checks every cycle against the schedule built from the opcode class.
   task automatic run_instr(input int d, input logic [3:0] op, input bit halt, input int waits,
                            input int stall_pos, input int stall_len, input int abort_at);
      int stg[$];
      int cs[$];
      bit cst[$];
      int mw;
      int n;
      bit jmp, br, alu, st;
      logic [9:0] exp_s;
      logic [31:0] exp_c;
      jmp = (op >= 4'd12) && (op <= 4'd14);
      br  = (op >= 4'd8) && (op <= 4'd11);
      alu = (op <= 4'd4);
      st  = (op == 4'd7) || (op == 4'd15);
      stg.push_back(0);
      stg.push_back(1);
      if (!jmp) begin
         repeat (exc(d)) stg.push_back(2);
         if (alu) stg.push_back(4);
         else if (!br) begin
            repeat (hs(d) ? 1 + waits : 1) stg.push_back(3);
            if (!st) stg.push_back(4);
         end
      end
      for (int i = 0; i < stg.size(); i++) begin
         if (i == stall_pos) begin
            repeat (stall_len) begin
               cs.push_back(stg[i]);
               cst.push_back(1'b1);
            end
         end
         cs.push_back(stg[i]);
         cst.push_back(1'b0);
      end
      mw = 0;
      for (int k = 0; k < cs.size(); k++) begin
         exp_s = {3'(cs[k]), en_of(cs[k]), exp_done[d], 1'b0};
         exp_c = {16'(exp_ic[d]), 16'(exp_cc[d])};
         total++;
         if (status(d) !== exp_s) begin
            bad++;
            $display("FAIL seq_status dut%0d op=%b cyc=%0d: got %b want %b", d, op, k, status(d), exp_s);
         end
         total++;
         if (counts(d) !== exp_c) begin
            bad++;
            $display("FAIL seq_counts dut%0d op=%b cyc=%0d: got %h want %h", d, op, k, counts(d), exp_c);
         end
         stall_v[d] = cst[k];
         op_v[d] = (cs[k] == 1 && !cst[k]) ? op : 4'($urandom);
         hreq_v[d] = (k == cs.size() - 1) ? halt : 1'($urandom);
         if (cs[k] == 3 && !cst[k] && hs(d)) begin
            mr_v[d] = (mw < waits) ? 1'b0 : 1'b1;
            mw++;
         end else begin
            mr_v[d] = 1'($urandom);
         end
         if (k == abort_at) begin
            rst_n_v[d] = 1'b0;
            stall_v[d] = 1'($urandom);
            step();
            total++;
            if (status(d) !== {3'd0, 5'b00001, 2'b00}) begin
               bad++;
               $display("FAIL abort_status dut%0d cyc=%0d: got %b want %b", d, k, status(d), {3'd0, 5'b00001, 2'b00});
            end
            total++;
            if (counts(d) !== 32'd0) begin
               bad++;
               $display("FAIL abort_counts dut%0d: got %h want 0", d, counts(d));
            end
            rst_n_v[d] = 1'b1;
            stall_v[d] = 1'b0;
            exp_ic[d] = 0;
            exp_cc[d] = 0;
            exp_done[d] = 1'b0;
            return;
         end
         step();
         exp_cc[d] = (exp_cc[d] + 1) & cmask(d);
         exp_done[d] = (k == cs.size() - 1);
         if (k == cs.size() - 1) exp_ic[d] = (exp_ic[d] + 1) & cmask(d);
      end
      if (halt) begin
         n = 3 + $urandom_range(0, 3);
         for (int j = 0; j < n; j++) begin
            exp_s = {3'd5, 5'd0, exp_done[d], 1'b1};
            exp_c = {16'(exp_ic[d]), 16'(exp_cc[d])};
            total++;
            if (status(d) !== exp_s) begin
               bad++;
               $display("FAIL halt_status dut%0d cyc=%0d: got %b want %b", d, j, status(d), exp_s);
            end
            total++;
            if (counts(d) !== exp_c) begin
               bad++;
               $display("FAIL halt_counts dut%0d cyc=%0d: got %h want %h", d, j, counts(d), exp_c);
            end
            stall_v[d] = 1'($urandom);
            hreq_v[d]  = 1'($urandom);
            op_v[d]    = 4'($urandom);
            mr_v[d]    = 1'($urandom);
            step();
            exp_done[d] = 1'b0;
         end
      end
   endtask

   task automatic test_basic_alu();
      test_reset(0);
      run_instr(0, 4'b0000, 1'b0, 0, -1, 0, -1);
      total++;
      if ({sn0, dn0, ic0} !== {3'd0, 1'b1, 16'd1}) begin
         bad++;
         $display("FAIL basic_retire: got stage=%0d done=%b icount=%0d want 0 1 1", sn0, dn0, ic0);
      end
   endtask

   task automatic test_mixed();
      test_reset(0);
      run_instr(0, 4'b1100, 1'b0, 0, -1, 0, -1);
      run_instr(0, 4'b1001, 1'b0, 0, -1, 0, -1);
      run_instr(0, 4'b0111, 1'b0, 0, -1, 0, -1);
      run_instr(0, 4'b0101, 1'b0, 0, -1, 0, -1);
      total++;
      if ({ic0, cc0} !== {16'd4, 16'd14}) begin
         bad++;
         $display("FAIL mixed_counts: got icount=%0d ccount=%0d want 4 14", ic0, cc0);
      end
   endtask

   task automatic test_mem_wait();
      test_reset(1);
      run_instr(1, 4'b0101, 1'b0, 2, -1, 0, -1);
      total++;
      if ({sn1, dn1, ic1, cc1} !== {3'd0, 1'b1, 4'd1, 4'd9}) begin
         bad++;
         $display("FAIL mem_wait_total: got stage=%0d done=%b icount=%0d ccount=%0d want 0 1 1 9", sn1, dn1, ic1, cc1);
      end
   endtask

   task automatic test_stall();
      test_reset(0);
      run_instr(0, 4'b0011, 1'b0, 0, 2, 5, -1);
      total++;
      if ({ic0, cc0} !== {16'd1, 16'd9}) begin
         bad++;
         $display("FAIL stall_counts: got icount=%0d ccount=%0d want 1 9", ic0, cc0);
      end
      run_instr(0, 4'b1010, 1'b0, 0, -1, 0, -1);
   endtask

   task automatic test_halt();
      test_reset(0);
      run_instr(0, 4'b0010, 1'b1, 0, -1, 0, -1);
      total++;
      if ({sn0, en0, h0, ic0, cc0} !== {3'd5, 5'd0, 1'b1, 16'd1, 16'd4}) begin
         bad++;
         $display("FAIL halt_sticky: got stage=%0d en=%b halted=%b icount=%0d ccount=%0d want 5 0 1 1 4", sn0, en0, h0, ic0, cc0);
      end
      test_reset(0);
      run_instr(0, 4'b0001, 1'b0, 0, -1, 0, -1);
   endtask

   task automatic test_wrap();
      test_reset(1);
      repeat (16) run_instr(1, 4'b1100, 1'b0, 0, -1, 0, -1);
      total++;
      if ({dn1, ic1} !== {1'b1, 4'd0}) begin
         bad++;
         $display("FAIL wrap_icount: got done=%b icount=%0d want 1 0", dn1, ic1);
      end
      run_instr(1, 4'b0111, 1'b0, 1, -1, 0, 5);
      run_instr(1, 4'b0000, 1'b0, 0, -1, 0, -1);
   endtask

   task automatic test_random();
      for (int d = 0; d < 2; d++) begin
         test_reset(d);
         for (int t = 0; t < 40; t++) begin
            logic [3:0] op;
            bit halt;
            int sp, ab;
            op = 4'($urandom);
            halt = ($urandom_range(0, 9) == 0);
            sp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 6)) : -1;
            ab = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 9)) : -1;
            run_instr(d, op, halt, int'($urandom_range(0, 3)), sp, int'($urandom_range(1, 4)), ab);
            if (halt) test_reset(d);
         end
      end
   endtask

   initial begin
      rst_n_v = 2'b00;
      stall_v = 2'b00;
      hreq_v  = 2'b00;
      mr_v    = 2'b00;
      op_v[0] = 4'd0;
      op_v[1] = 4'd0;
      step();
      test_reset(0);
      test_reset(1);
      test_basic_alu();
      test_mixed();
      test_mem_wait();
      test_stall();
      test_halt();
      test_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
